// File: rtl/data_mem_arbiter.sv
// Two-port arbiter for the single-port data memory: round-robin grant with
// locked bursts capped at MAX_BURST beats, plus a sticky illegal-store flag.
module data_mem_arbiter #(
    parameter int unsigned ADDRESS_WIDTH = 32,
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned MAX_BURST     = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [1:0]                   req,
    input  logic [1:0]                   lock,
    input  logic [1:0]                   we,
    input  logic [2*ADDRESS_WIDTH-1:0]   a,
    input  logic [2*DATA_WIDTH-1:0]      wdata,
    input  logic [5:0]                   memctrl,
    output logic [1:0]                   ack,
    output logic [2*DATA_WIDTH-1:0]      rdata,
    output logic [ADDRESS_WIDTH-1:0]     mem_a,
    output logic                         mem_we,
    output logic [DATA_WIDTH-1:0]        mem_writedata,
    output logic [2:0]                   mem_memcontrol,
    input  logic [DATA_WIDTH-1:0]        mem_readdata,
    output logic                         store_err
);

    localparam int unsigned AW = ADDRESS_WIDTH;
    localparam int unsigned DW = DATA_WIDTH;
    localparam int unsigned BW = $clog2(MAX_BURST + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    state_t          r_state, w_state_nxt;
    logic            r_prio, w_prio_nxt;
    logic [BW-1:0]   r_beat, w_beat_nxt;
    logic            r_store_err, w_store_err_nxt;

    logic            w_cont;
    logic            w_grant;
    logic            w_g;
    logic [2:0]      w_ctrl;
    logic            w_legal;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_prio      <= 1'b0;
            r_beat      <= '0;
            r_store_err <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_prio      <= w_prio_nxt;
            r_beat      <= w_beat_nxt;
            r_store_err <= w_store_err_nxt;
        end
    end

    // Grant selection, memory-side muxing and next-state
    always_comb begin
        w_state_nxt     = r_state;
        w_prio_nxt      = r_prio;
        w_beat_nxt      = r_beat;
        w_store_err_nxt = r_store_err;
        w_cont          = 1'b0;
        w_grant         = 1'b0;
        w_g             = 1'b0;
        ack             = 2'b00;
        mem_a           = '0;
        mem_we          = 1'b0;
        mem_writedata   = '0;
        mem_memcontrol  = 3'b010;
        w_ctrl          = 3'b010;
        w_legal         = 1'b1;

        // A burst continues only while the owner keeps both req and lock
        if (r_beat < BW'(MAX_BURST)) begin
            if (r_state == OWN0 && req[0] && lock[0]) begin
                w_cont = 1'b1;
                w_g    = 1'b0;
            end else if (r_state == OWN1 && req[1] && lock[1]) begin
                w_cont = 1'b1;
                w_g    = 1'b1;
            end
        end

        if (w_cont) begin
            w_grant = 1'b1;
        end else if (req == 2'b11) begin
            w_grant = 1'b1;
            w_g     = r_prio;
        end else if (req[0]) begin
            w_grant = 1'b1;
            w_g     = 1'b0;
        end else if (req[1]) begin
            w_grant = 1'b1;
            w_g     = 1'b1;
        end

        if (w_grant) begin
            w_ctrl         = w_g ? memctrl[5:3] : memctrl[2:0];
            w_legal        = (w_ctrl == 3'b000) || (w_ctrl == 3'b001) || (w_ctrl == 3'b010);
            ack            = w_g ? 2'b10 : 2'b01;
            mem_a          = w_g ? a[2*AW-1:AW] : a[AW-1:0];
            mem_writedata  = w_g ? wdata[2*DW-1:DW] : wdata[DW-1:0];
            mem_memcontrol = w_ctrl;
            mem_we         = we[w_g] & w_legal;
            if (we[w_g] && !w_legal) begin
                w_store_err_nxt = 1'b1;
            end
            if (w_cont) begin
                w_beat_nxt = BW'(r_beat + 1'b1);
            end else begin
                w_state_nxt = w_g ? OWN1 : OWN0;
                w_beat_nxt  = BW'(1);
                w_prio_nxt  = ~w_g;
            end
        end else begin
            w_state_nxt = IDLE;
            w_beat_nxt  = '0;
        end

        // Nothing may be acknowledged or committed while reset is asserted
        if (rst) begin
            ack    = 2'b00;
            mem_we = 1'b0;
        end
    end

    assign rdata     = {mem_readdata, mem_readdata};
    assign store_err = r_store_err;

endmodule

// File: doc/data_mem_arbiter.md
Name: data_mem_arbiter

Overview:
Shares the single-port, byte-addressed data memory between two requesters. Port 0 is the CPU load/store unit; port 1 is a secondary master (program loader / DMA).
- Grants at most one access per cycle, combinationally, so a load completes in the granted cycle (memory read is asynchronous) and a store commits at the next posedge.
- Sequential state: round-robin priority pointer, ownership FSM and burst-beat counter for locked bursts.
- Also flags illegal store encodings.

Parameters:
ADDRESS_WIDTH, 32, address width per port
DATA_WIDTH, 32, data width per port
MAX_BURST, 4, max consecutive locked beats one port may hold (>=1)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-high reset
req  input  2  bit k: port k requests an access this cycle
lock  input  2  bit k: port k wants to keep ownership next cycle (burst)
we  input  2  bit k: port k request is a store
a  input  2*ADDRESS_WIDTH  port k address in bits [k*AW +: AW]
wdata  input  2*DATA_WIDTH  port k store data in bits [k*DW +: DW]
memctrl  input  6  port k funct3 in bits [k*3 +: 3]
ack  output  2  bit k: port k access performed this cycle (one-hot or zero)
rdata  output  2*DATA_WIDTH  mem_readdata copied to both slices; valid only in the slice whose ack is high
mem_a  output  ADDRESS_WIDTH  to memory address
mem_we  output  1  to memory write enable
mem_writedata  output  DATA_WIDTH  to memory write data
mem_memcontrol  output  3  to memory funct3
mem_readdata  input  DATA_WIDTH  from memory read data
store_err  output  1  sticky: an illegal store was suppressed

Behaviour:
State registers:
- FSM state in {IDLE, OWN0, OWN1}.
- prio (1 bit): port preferred on a tie.
- beat_cnt ($clog2(MAX_BURST+1) bits).
- store_err.
- Reset values: IDLE, prio=0, beat_cnt=0, store_err=0.
- While rst is high, ack=00 and mem_we=0.

Grant selection (combinational, g = granted port):
- Continuation: state==OWNk and req[k] and lock[k] and beat_cnt<MAX_BURST -> g=k. The other port is blocked even if requesting.
- Otherwise, arbitrated grant:
  - both requesting -> g=prio
  - one requesting -> g is that port
  - none requesting -> no grant

Outputs with a grant:
- ack[g]=1.
- mem_a, mem_writedata and mem_memcontrol are taken from port g.
- mem_we=we[g] & legal. A store is legal only if memctrl is 000, 001 or 010.

Outputs with no grant:
- ack=00, mem_we=0, mem_a=0, mem_writedata=0, mem_memcontrol=3'b010 (harmless load word).

Posedge update:
- Continuation: beat_cnt<=beat_cnt+1; state unchanged.
- Arbitrated grant: state<=OWNg; beat_cnt<=1; prio<=~g.
- No grant: state<=IDLE; beat_cnt<=0; prio unchanged.
- Grant with we[g]=1 and illegal memctrl (011, 1xx): store_err<=1. It holds until reset.

Boundary conditions:
- beat_cnt==MAX_BURST ends the burst. That cycle is re-arbitrated; if the other port is idle, the same port is re-granted with beat_cnt<=1.
- Lock is ignored unless the port also requests.
- Dropping req mid-burst ends ownership immediately.
- Reset mid-burst: ownership and beat_cnt are cleared asynchronously. A store in that cycle is not committed (mem_we forced 0).
- rdata is pass-through: zero-latency loads; stores complete at the edge ending the ack cycle.

Test Plan:
- Reset then req=11, lock=00, held 4 cycles -> ack sequence 01,10,01,10; prio toggles each cycle.
- Port1 store, a=0x10000, wdata=0xCAFEBABE, memctrl=010 for 1 cycle; next cycle port0 load word at 0x10000 -> ack=01, rdata[31:0]=0xCAFEBABE.
- MAX_BURST=4; port0 req+lock continuously, port1 req from cycle 1 -> port0 acked cycles 0-3, port1 acked cycle 4, beat_cnt reaches 4 before release.
- Port0 store with memctrl=101 -> ack=01, mem_we=0, store_err=1 next cycle and held; a later legal store does not clear it.
- Port1 locked burst at beat 2, assert rst for 1 cycle mid-cycle -> ack=00 and mem_we=0 immediately; state=IDLE, prio=0, beat_cnt=0; after release, req=11 grants port0.
- req=00 for 3 cycles -> ack=00, mem_we=0, mem_memcontrol=010, state IDLE, prio unchanged.
